// File: rtl/integ_pkg.sv
// Shared types and helpers for the multichannel integrator and its step datapath.
package integ_pkg;

    typedef enum logic [1:0] {IDLE, RUN, BUSY, DONE} state_t;

    localparam logic MODE_RECT = 1'b0;
    localparam logic MODE_TRAP = 1'b1;

    localparam int BOUND_W = 128;

    // Two's-complement limits of an accW-bit accumulator, widened so callers can truncate to any width.
    function automatic logic signed [BOUND_W-1:0] sat_bound(input int accW, input logic wantMax);
        logic signed [BOUND_W-1:0] lim;
        lim = {{(BOUND_W-1){1'b0}}, 1'b1};
        lim = lim <<< (accW - 1);
        return wantMax ? (lim - BOUND_W'(1)) : -lim;
    endfunction

endpackage

// File: rtl/integ_step_dp.sv
// Combinational single-channel integration step: computes the increment, adds it to the
// accumulator and clamps the sum to the accumulator range.
module integ_step_dp
    import integ_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int ACC_W = 64,
    parameter int DT_W  = 16,
    parameter int SHIFT = 10
) (
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [IN_W-1:0]  prev,
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [DT_W-1:0]  dt,
    input  logic                    mode,
    input  logic                    first,
    output logic signed [ACC_W-1:0] next_acc,
    output logic                    sat
);

    localparam int EW = ACC_W + DT_W + 2;
    localparam logic signed [EW-1:0] MAX_V = EW'(sat_bound(ACC_W, 1'b1));
    localparam logic signed [EW-1:0] MIN_V = EW'(sat_bound(ACC_W, 1'b0));

    logic signed [EW-1:0] w_x;
    logic signed [EW-1:0] w_prev;
    logic signed [EW-1:0] w_dt;
    logic signed [EW-1:0] w_sum;
    logic signed [EW-1:0] w_prod;
    logic signed [EW-1:0] w_inc;
    logic signed [EW-1:0] w_total;
    logic signed [EW-1:0] w_clamp;

    // With no previous sample the trapezoid uses x twice, which collapses to the rectangle result.
    always_comb begin
        w_x    = EW'(x);
        w_prev = first ? w_x : EW'(prev);
        w_dt   = EW'(dt);
        w_sum  = (mode == MODE_TRAP) ? (w_x + w_prev) : w_x;
        w_prod = w_sum * w_dt;
        w_inc  = (mode == MODE_TRAP) ? (w_prod >>> (SHIFT + 1)) : (w_prod >>> SHIFT);
        w_total = EW'(acc) + w_inc;
        sat     = 1'b0;
        w_clamp = w_total;
        if (w_total > MAX_V) begin
            w_clamp = MAX_V;
            sat     = 1'b1;
        end else if (w_total < MIN_V) begin
            w_clamp = MIN_V;
            sat     = 1'b1;
        end
        next_acc = w_clamp[ACC_W-1:0];
    end

endmodule

// File: rtl/multichannel_integrator.sv
// Integrates CH signed sample streams through one shared step datapath, one channel per cycle,
// with a valid/ready input, sticky per-channel saturation and a one-cycle result strobe.
module multichannel_integrator
    import integ_pkg::*;
#(
    parameter int CH    = 4,
    parameter int IN_W  = 32,
    parameter int ACC_W = 64,
    parameter int DT_W  = 16,
    parameter int SHIFT = 10
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  mode,
    input  logic [DT_W-1:0]       dt,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [CH*IN_W-1:0]    sample_data,
    output logic                  result_valid,
    output logic [CH*ACC_W-1:0]   result_data,
    output logic [CH-1:0]         saturated,
    output logic [31:0]           sample_count
);

    localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [IDX_W-1:0]        r_idx;
    logic [CH*IN_W-1:0]      r_data;
    logic                    r_mode;
    logic [DT_W-1:0]         r_dt;
    logic signed [ACC_W-1:0] r_acc [CH];
    logic signed [IN_W-1:0]  r_prev [CH];
    logic                    r_first;
    logic                    r_resultValid;
    logic [CH*ACC_W-1:0]     r_resultData;
    logic [CH-1:0]           r_sat;
    logic [31:0]             r_count;

    logic                    w_handshake;
    logic                    w_lastCh;
    logic signed [IN_W-1:0]  w_x;
    logic signed [IN_W-1:0]  w_prev;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_nextAcc;
    logic                    w_sat;

    // Clear and reset both block a transfer in the cycle they are asserted.
    assign sample_ready = (r_state == RUN) && !clear && !resetb;
    assign w_handshake  = sample_valid && sample_ready;
    assign w_lastCh     = (r_idx == IDX_W'(CH - 1));
    assign result_valid = r_resultValid && !clear && !resetb;
    assign result_data  = r_resultData;
    assign saturated    = r_sat;
    assign sample_count = r_count;

    always_comb begin
        w_x    = '0;
        w_prev = '0;
        w_acc  = '0;
        for (int k = 0; k < CH; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_x    = r_data[k*IN_W +: IN_W];
                w_prev = r_prev[k];
                w_acc  = r_acc[k];
            end
        end
    end

    integ_step_dp #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .DT_W  (DT_W),
        .SHIFT (SHIFT)
    ) u_step (
        .x        (w_x),
        .prev     (w_prev),
        .acc      (w_acc),
        .dt       (r_dt),
        .mode     (r_mode),
        .first    (r_first),
        .next_acc (w_nextAcc),
        .sat      (w_sat)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (enable) w_nextState = RUN;
            RUN: begin
                if (w_handshake)  w_nextState = BUSY;
                else if (!enable) w_nextState = IDLE;
            end
            BUSY:    if (w_lastCh) w_nextState = DONE;
            DONE:    w_nextState = enable ? RUN : IDLE;
            default: w_nextState = IDLE;
        endcase
        if (clear) w_nextState = enable ? RUN : IDLE;
    end

    // The result register is loaded on the edge that finishes the last channel, so the
    // strobe and data appear together in the DONE cycle.
    always_ff @(posedge clk) begin
        if (resetb || clear) begin
            r_state       <= resetb ? IDLE : w_nextState;
            r_idx         <= '0;
            r_first       <= 1'b1;
            r_resultValid <= 1'b0;
            r_resultData  <= '0;
            r_sat         <= '0;
            r_count       <= '0;
            for (int k = 0; k < CH; k++) begin
                r_acc[k]  <= '0;
                r_prev[k] <= '0;
            end
        end else begin
            r_state       <= w_nextState;
            r_resultValid <= 1'b0;
            if (w_handshake) begin
                r_data <= sample_data;
                r_mode <= mode;
                r_dt   <= dt;
                r_idx  <= '0;
            end
            if (r_state == BUSY) begin
                for (int k = 0; k < CH; k++) begin
                    if (r_idx == IDX_W'(k)) begin
                        r_acc[k]  <= w_nextAcc;
                        r_prev[k] <= w_x;
                        if (w_sat) r_sat[k] <= 1'b1;
                    end
                end
                r_idx <= r_idx + IDX_W'(1);
                if (w_lastCh) begin
                    r_first       <= 1'b0;
                    r_resultValid <= 1'b1;
                    r_count       <= r_count + 32'd1;
                    for (int k = 0; k < CH; k++) begin
                        r_resultData[k*ACC_W +: ACC_W] <= (k == CH - 1) ? w_nextAcc : r_acc[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multichannel_integrator.sv
// Randomised self-checking bench: a whole-vector arithmetic model runs beside a 64-bit and a 16-bit accumulator instance.
module tb_multichannel_integrator;

    localparam int CH    = 4;
    localparam int IN_W  = 32;
    localparam int ACC_W = 64;
    localparam int DT_W  = 16;
    localparam int SHIFT = 10;
    localparam int ACC2  = 16;

    logic                  clk = 1'b0;
    logic                  resetb;
    logic                  enable;
    logic                  clear;
    logic                  mode;
    logic [DT_W-1:0]       dt;
    logic                  sampleValid;
    logic [CH*IN_W-1:0]    sampleData;

    logic                  sampleReady;
    logic                  resultValid;
    logic [CH*ACC_W-1:0]   resultData;
    logic [CH-1:0]         saturated;
    logic [31:0]           sampleCount;

    logic                  sampleReadyB;
    logic                  resultValidB;
    logic [CH*ACC2-1:0]    resultDataB;
    logic [CH-1:0]         saturatedB;
    logic [31:0]           sampleCountB;

    int checks   = 0;
    int failures = 0;

    logic signed [127:0]   mAcc [2][CH];
    logic signed [IN_W-1:0] mPrev [CH];
    bit                    mFirst;
    logic [CH-1:0]         mSat [2];
    int unsigned           mCount;

    multichannel_integrator #(.CH(CH), .IN_W(IN_W), .ACC_W(ACC_W), .DT_W(DT_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .resetb(resetb), .enable(enable), .clear(clear), .mode(mode), .dt(dt),
        .sample_valid(sampleValid), .sample_ready(sampleReady), .sample_data(sampleData),
        .result_valid(resultValid), .result_data(resultData), .saturated(saturated),
        .sample_count(sampleCount)
    );

    multichannel_integrator #(.CH(CH), .IN_W(IN_W), .ACC_W(ACC2), .DT_W(DT_W), .SHIFT(SHIFT)) dutSat (
        .clk(clk), .resetb(resetb), .enable(enable), .clear(clear), .mode(mode), .dt(dt),
        .sample_valid(sampleValid), .sample_ready(sampleReadyB), .sample_data(sampleData),
        .result_valid(resultValidB), .result_data(resultDataB), .saturated(saturatedB),
        .sample_count(sampleCountB)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic signed [127:0] clampTo(input logic signed [127:0] v, input int w, output bit hit);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi  = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo  = -(128'sd1 <<< (w - 1));
        hit = 1'b0;
        if (v > hi) begin hit = 1'b1; return hi; end
        if (v < lo) begin hit = 1'b1; return lo; end
        return v;
    endfunction

    task automatic modelClear();
        for (int k = 0; k < CH; k++) begin
            mAcc[0][k] = '0;
            mAcc[1][k] = '0;
            mPrev[k]   = '0;
        end
        mSat[0] = '0;
        mSat[1] = '0;
        mFirst  = 1'b1;
        mCount  = 0;
    endtask

    // Whole-vector update at the moment of acceptance; the DUT shows it CH+1 cycles later.
    task automatic modelApply(input logic [CH*IN_W-1:0] d, input logic m, input logic [DT_W-1:0] t);
        logic signed [IN_W-1:0] xs;
        logic signed [127:0] xv, pv, dv, inc;
        bit hit;
        for (int k = 0; k < CH; k++) begin
            xs = d[k*IN_W +: IN_W];
            xv = xs;
            pv = mPrev[k];
            dv = 128'(t);
            if (m && !mFirst) inc = ((xv + pv) * dv) >>> (SHIFT + 1);
            else              inc = (xv * dv) >>> SHIFT;
            mAcc[0][k] = clampTo(mAcc[0][k] + inc, ACC_W, hit);
            if (hit) mSat[0][k] = 1'b1;
            mAcc[1][k] = clampTo(mAcc[1][k] + inc, ACC2, hit);
            if (hit) mSat[1][k] = 1'b1;
            mPrev[k] = xs;
        end
        mFirst = 1'b0;
        mCount++;
    endtask

    // Offers one vector, then returns at the negedge where result_valid is seen (lat = -1 on timeout).
    task automatic applyStimulus(input logic [CH*IN_W-1:0] d, input logic m, input logic [DT_W-1:0] t,
                                 output int lat, output bit readyLow);
        int n;
        @(negedge clk);
        sampleData  = d;
        mode        = m;
        dt          = t;
        sampleValid = 1'b1;
        n = 0;
        #1;
        while (!sampleReady && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        readyLow = 1'b1;
        if (!sampleReady) begin
            lat = -1;
            sampleValid = 1'b0;
            return;
        end
        modelApply(d, m, t);
        @(negedge clk);
        sampleValid = 1'b0;
        sampleData  = {$urandom, $urandom, $urandom, $urandom};
        mode        = ~m;
        dt          = DT_W'($urandom);
        lat = 1;
        while (!resultValid && lat < 50) begin
            if (sampleReady) readyLow = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (sampleReady) readyLow = 1'b0;
        if (!resultValid) lat = -1;
    endtask

    task automatic doClear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        modelClear();
    endtask

    task automatic test_reset();
        resetb      = 1'b1;
        enable      = 1'b0;
        clear       = 1'b0;
        mode        = 1'b0;
        dt          = '0;
        sampleValid = 1'b1;
        sampleData  = {$urandom, $urandom, $urandom, $urandom};
        modelClear();
        repeat (2) @(negedge clk);
        checks++; if (sampleReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", sampleReady); end
        checks++; if (resultValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", resultValid); end
        checks++; if (resultData !== '0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", resultData); end
        checks++; if (saturated !== '0) begin failures++; $display("[TB] FAIL reset_sat: got %b expected 0", saturated); end
        checks++; if (sampleCount !== 32'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", sampleCount); end
        resetb = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (sampleReady !== 1'b0 || resultValid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_no_accept: got ready=%b valid=%b expected 0/0", sampleReady, resultValid);
            end
        end
        sampleValid = 1'b0;
    endtask

    task automatic test_trap_ch0();
        logic [CH*IN_W-1:0] d;
        int lat;
        bit rl;
        logic signed [ACC_W-1:0] expCh0 [2];
        expCh0[0] = 100;
        expCh0[1] = 300;
        enable = 1'b1;
        for (int v = 0; v < 2; v++) begin
            d = '0;
            d[0 +: IN_W] = (v == 0) ? 32'd100 : 32'd300;
            applyStimulus(d, 1'b1, 16'd1024, lat, rl);
            checks++; if (lat != CH + 1) begin failures++; $display("[TB] FAIL trap_latency: got %0d expected %0d", lat, CH + 1); end
            checks++; if (!rl) begin failures++; $display("[TB] FAIL trap_ready_low: got ready high expected low during BUSY/DONE"); end
            checks++;
            if (resultData[0 +: ACC_W] !== expCh0[v]) begin
                failures++;
                $display("[TB] FAIL trap_ch0: got %0d expected %0d", $signed(resultData[0 +: ACC_W]), expCh0[v]);
            end
        end
        checks++; if (sampleCount !== 32'd2) begin failures++; $display("[TB] FAIL trap_count: got %0d expected 2", sampleCount); end
    endtask

    task automatic test_rect_multi();
        logic [CH*IN_W-1:0] d;
        logic signed [ACC_W-1:0] expv [CH];
        int lat;
        bit rl;
        doClear();
        checks++;
        if (sampleCount !== 32'd0 || resultData !== '0) begin
            failures++;
            $display("[TB] FAIL clear_state: got count=%0d data=%h expected 0/0", sampleCount, resultData);
        end
        d = {32'h7fff_ffff, 32'd0, -32'sd10, 32'sd10};
        expv[0] = 5; expv[1] = -5; expv[2] = 0; expv[3] = 64'd1073741823;
        applyStimulus(d, 1'b0, 16'd512, lat, rl);
        checks++; if (lat != CH + 1) begin failures++; $display("[TB] FAIL rect_latency: got %0d expected %0d", lat, CH + 1); end
        checks++; if (!rl) begin failures++; $display("[TB] FAIL rect_ready_low: got ready high expected low for T+1..T+%0d", CH + 1); end
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (resultData[k*ACC_W +: ACC_W] !== expv[k]) begin
                failures++;
                $display("[TB] FAIL rect_ch%0d: got %0d expected %0d", k, $signed(resultData[k*ACC_W +: ACC_W]), expv[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [CH*IN_W-1:0] d;
        logic m;
        logic [DT_W-1:0] t;
        int lat;
        bit rl;
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < CH; k++) d[k*IN_W +: IN_W] = $urandom;
            m = 1'($urandom_range(0, 1));
            t = (it == 3) ? '0 : DT_W'($urandom_range(0, 4096));
            applyStimulus(d, m, t, lat, rl);
            checks++; if (lat != CH + 1) begin failures++; $display("[TB] FAIL rand_latency: got %0d expected %0d", lat, CH + 1); end
            for (int k = 0; k < CH; k++) begin
                checks++;
                if (resultData[k*ACC_W +: ACC_W] !== mAcc[0][k][ACC_W-1:0]) begin
                    failures++;
                    $display("[TB] FAIL rand_ch%0d: got %0d expected %0d (mode=%0d dt=%0d)", k,
                             $signed(resultData[k*ACC_W +: ACC_W]), $signed(mAcc[0][k][ACC_W-1:0]), m, t);
                end
            end
            checks++; if (saturated !== mSat[0]) begin failures++; $display("[TB] FAIL rand_sat: got %b expected %b", saturated, mSat[0]); end
            checks++; if (sampleCount !== mCount) begin failures++; $display("[TB] FAIL rand_count: got %0d expected %0d", sampleCount, mCount); end
        end
    endtask

    task automatic test_saturation();
        logic [CH*IN_W-1:0] d;
        logic signed [ACC2-1:0] expv [3];
        logic expSat [3];
        logic signed [IN_W-1:0] xs [3];
        int lat;
        bit rl;
        xs[0] = 20000; xs[1] = 20000; xs[2] = -20000;
        expv[0] = 20000; expv[1] = 32767; expv[2] = 12767;
        expSat[0] = 1'b0; expSat[1] = 1'b1; expSat[2] = 1'b1;
        doClear();
        for (int v = 0; v < 3; v++) begin
            d = '0;
            d[0 +: IN_W] = xs[v];
            applyStimulus(d, 1'b0, 16'd1024, lat, rl);
            checks++;
            if (resultDataB[0 +: ACC2] !== expv[v] || resultDataB[0 +: ACC2] !== mAcc[1][0][ACC2-1:0]) begin
                failures++;
                $display("[TB] FAIL sat_acc16: got %0d expected %0d", $signed(resultDataB[0 +: ACC2]), expv[v]);
            end
            checks++;
            if (saturatedB[0] !== expSat[v]) begin
                failures++;
                $display("[TB] FAIL sat_flag16: got %b expected %b", saturatedB[0], expSat[v]);
            end
            checks++;
            if (resultData[0 +: ACC_W] !== mAcc[0][0][ACC_W-1:0] || saturated !== '0) begin
                failures++;
                $display("[TB] FAIL sat_acc64: got %0d/%b expected %0d/0", $signed(resultData[0 +: ACC_W]), saturated,
                         $signed(mAcc[0][0][ACC_W-1:0]));
            end
        end
    endtask

    task automatic test_clear_busy();
        logic [CH*IN_W-1:0] d;
        bit seenValid;
        int n;
        int lat;
        bit rl;
        d = '0;
        d[0 +: IN_W] = 77;
        @(negedge clk);
        sampleData  = d;
        mode        = 1'b1;
        dt          = 16'd1024;
        sampleValid = 1'b1;
        n = 0;
        #1;
        while (!sampleReady && n < 50) begin @(negedge clk); #1; n++; end
        checks++; if (!sampleReady) begin failures++; $display("[TB] FAIL clr_accept: got ready=0 expected 1"); end
        modelApply(d, 1'b1, 16'd1024);
        seenValid = 1'b0;
        @(negedge clk);
        sampleValid = 1'b0;
        if (resultValid) seenValid = 1'b1;
        @(negedge clk);
        clear = 1'b1;
        #1;
        if (resultValid) seenValid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        modelClear();
        for (int c = 0; c < 8; c++) begin
            if (resultValid) seenValid = 1'b1;
            @(negedge clk);
        end
        checks++; if (seenValid) begin failures++; $display("[TB] FAIL clr_no_valid: got result_valid=1 expected 0"); end
        checks++;
        if (resultData !== '0 || sampleCount !== 32'd0) begin
            failures++;
            $display("[TB] FAIL clr_zero: got count=%0d data=%h expected 0/0", sampleCount, resultData);
        end
        d[0 +: IN_W] = 50;
        applyStimulus(d, 1'b1, 16'd1024, lat, rl);
        checks++;
        if (resultData[0 +: ACC_W] !== 64'd50 || sampleCount !== 32'd1) begin
            failures++;
            $display("[TB] FAIL clr_first_flag: got %0d count=%0d expected 50 count=1", $signed(resultData[0 +: ACC_W]), sampleCount);
        end
    endtask

    task automatic test_back_to_back_enable();
        logic [CH*IN_W-1:0] d;
        int unsigned c0;
        int pulses;
        int n;
        bit readySeen;
        bit dataOk;
        for (int k = 0; k < CH; k++) d[k*IN_W +: IN_W] = IN_W'($urandom_range(0, 100000));
        c0 = mCount;
        @(negedge clk);
        sampleData  = d;
        mode        = 1'b0;
        dt          = 16'd1024;
        sampleValid = 1'b1;
        n = 0;
        #1;
        while (!sampleReady && n < 50) begin @(negedge clk); #1; n++; end
        modelApply(d, 1'b0, 16'd1024);
        @(negedge clk);
        enable = 1'b0;
        pulses = 0;
        readySeen = 1'b0;
        dataOk = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (sampleReady) readySeen = 1'b1;
            if (resultValid) begin
                pulses++;
                for (int k = 0; k < CH; k++)
                    if (resultData[k*ACC_W +: ACC_W] !== mAcc[0][k][ACC_W-1:0]) dataOk = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL en_drop_pulses: got %0d expected 1", pulses); end
        checks++; if (!dataOk) begin failures++; $display("[TB] FAIL en_drop_data: got wrong result_data expected model values"); end
        checks++; if (readySeen) begin failures++; $display("[TB] FAIL en_drop_ready: got ready=1 expected 0 while enable low"); end
        checks++; if (sampleCount !== c0 + 1) begin failures++; $display("[TB] FAIL en_drop_count: got %0d expected %0d", sampleCount, c0 + 1); end
        enable = 1'b1;
        n = 0;
        #1;
        while (!sampleReady && n < 50) begin @(negedge clk); #1; n++; end
        checks++; if (!sampleReady) begin failures++; $display("[TB] FAIL en_resume: got ready=0 expected 1"); end
        modelApply(d, 1'b0, 16'd1024);
        @(negedge clk);
        sampleValid = 1'b0;
        n = 1;
        while (!resultValid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (resultData[0 +: ACC_W] !== mAcc[0][0][ACC_W-1:0] || sampleCount !== c0 + 2) begin
            failures++;
            $display("[TB] FAIL en_second: got %0d count=%0d expected %0d count=%0d", $signed(resultData[0 +: ACC_W]),
                     sampleCount, $signed(mAcc[0][0][ACC_W-1:0]), c0 + 2);
        end
    endtask

    initial begin
        test_reset();
        test_trap_ch0();
        test_rect_multi();
        test_random();
        test_saturation();
        test_clear_busy();
        test_back_to_back_enable();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multichannel_integrator.md
Name: multichannel_integrator

Overview:
Parametrised successor to the single-channel numerical integrator in the velocity→height→gimbal chain. It integrates CH signed sample streams at once (velocity, acceleration and angular-rate channels), in rectangular or trapezoidal mode. Each integration uses a runtime time step and a fixed-point scale. The block has a valid/ready input handshake, per-channel saturation and a result-valid strobe, so the gimbal controller can consume all heights and angles in one update.

Parameters:
CH, 4, number of independent channels
IN_W, 32, signed sample width per channel
ACC_W, 64, signed accumulator/result width per channel
DT_W, 16, unsigned time-step width
SHIFT, 10, fixed-point fraction bits of dt (dt=1024 means 1.0)

Ports:
clk  in  1  single clock, rising edge
resetb  in  1  reset, synchronous, active-high (asserted = 1 despite the legacy name)
enable  in  1  level; integration runs while high
clear  in  1  synchronous clear of all integration state
mode  in  1  0 = rectangular, 1 = trapezoidal; sampled on handshake
dt  in  DT_W  time step; sampled on handshake
sample_valid  in  1  sample vector present
sample_ready  out  1  block can accept a vector
sample_data  in  CH*IN_W  channel k in bits [k*IN_W +: IN_W]
result_valid  out  1  one-cycle strobe; result_data updated
result_data  out  CH*ACC_W  accumulators, channel k in bits [k*ACC_W +: ACC_W]
saturated  out  CH  sticky per-channel saturation flag
sample_count  out  32  accepted vectors since last clear, wraps at 2^32

Behaviour:
- Reset (resetb=1 at clk edge) forces the following. All outputs go to 0: sample_ready, result_valid, result_data, saturated and sample_count. All accumulators and prev-samples go to 0, first-flag goes to 1, and the FSM goes to IDLE. Reset overrides everything, including a transfer mid-BUSY.
- FSM states:
  - IDLE: entered when enable=0. sample_ready=0 and accumulators hold. Goes to RUN when enable=1.
  - RUN: sample_ready=1. On sample_valid & sample_ready (cycle T), latches sample_data, mode and dt, and goes to BUSY. Goes to IDLE if enable=0 and no handshake that cycle.
  - BUSY: one channel per cycle, channel 0 at T+1 through channel CH-1 at T+CH. Serial channel processing through a shared datapath is required. sample_ready=0. Goes to DONE.
  - DONE (T+CH+1): copies all accumulators to result_data, pulses result_valid for exactly 1 cycle and increments sample_count. Goes to RUN if enable=1, otherwise IDLE.
- Handshake: a vector transfers only on valid&ready. The source must hold sample_data stable while valid=1 and ready=0. Maximum throughput is one vector per CH+2 cycles.
- Increment arithmetic: full-width signed multiply with no intermediate truncation, then an arithmetic right shift (rounds toward −inf). Operands are sign-extended to ACC_W+DT_W+2 bits.
  - rect: inc = (x·dt) >>> SHIFT.
  - trap: inc = ((x+prev)·dt) >>> (SHIFT+1).
  - First vector after reset or clear: the trapezoid uses prev = x, so it equals rect. first-flag then clears.
- prev: each channel's prev-sample is updated to x after its step, in both modes.
- Saturation: acc+inc is clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. On clamp, saturated[k] is set and stays set until clear or reset. A saturated accumulator can still move back inward.
- dt = 0: inc = 0, but the vector still counts and result_valid still pulses.
- clear (when resetb=0):
  - Same effect as reset on accumulators, prev, first-flag, saturated, sample_count and result_data.
  - The FSM goes to RUN if enable=1, otherwise IDLE.
  - sample_ready is forced to 0 during the clear cycle, so clear and sample_valid together means no transfer.
  - A clear during BUSY/DONE aborts the vector and no result_valid is issued.
- enable dropping during BUSY does not abort. The vector completes and the FSM then enters IDLE.
- resetb and clear together: reset wins (identical state except FSM → IDLE).

Decomposition:
- Package integ_pkg:
  - FSM state enum (IDLE, RUN, BUSY, DONE).
  - Mode constants MODE_RECT=0 and MODE_TRAP=1.
  - A function computing the saturation bounds from ACC_W.
- Sub-module integ_step_dp: combinational single-channel datapath. Inputs: x, prev, acc, dt, mode, first. Outputs: next_acc and sat. It is parametrised by IN_W, ACC_W, DT_W and SHIFT. The top holds the FSM, channel index counter, accumulator/prev arrays and output registers.

Test Plan:
- Reset/idle: hold resetb=1 for 2 cycles with enable=0 → all outputs 0; sample_valid=1 is never accepted; no result_valid.
- Trapezoid ch0: enable=1, mode=1, dt=1024, ch0 samples 100 then 300 → result ch0 = 100 after the first vector and 300 after the second. result_valid comes exactly CH+1=5 cycles after each handshake. sample_count=2.
- Rectangular multi-channel: mode=0, dt=512, vector {ch0=10, ch1=−10, ch2=0, ch3=2^31−1} → results {5, −5, 0, 1073741823}. sample_ready is low for cycles T+1..T+5.
- Saturation (ACC_W=16): mode=0, dt=1024, ch0 = 20000 twice → 20000, then 32767 with saturated[0]=1. Then ch0 = −20000 → 12767 with saturated[0] still 1.
- Clear mid-BUSY: assert clear at T+2 → no result_valid, all results and count 0. The next vector 50 (trap, dt=1024) gives 50, confirming first-flag was restored.
- Backpressure/enable: hold sample_valid=1 with changing enable. Deassert enable at T+1 → that vector still completes with result_valid, then sample_ready=0 until enable returns. Exactly one vector is accepted per handshake, with no duplicates.
